// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C command arbiter: FSM encodings,
// operation codes and the default completion timeout.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic READ_OP  = 1'b1;
    localparam logic WRITE_OP = 1'b0;

    localparam logic [15:0] TIMEOUT_DEFAULT = 16'hFFFF;

    // Width of a requester index; a lone requester still needs one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_arb_rr_pick.sv
// Round-robin picker: first pending requester at or after last_grant+1,
// wrapping modulo NUM_REQ.
module i2c_arb_rr_pick
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int GW      = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [GW-1:0]      last_grant,
    output logic [GW-1:0]      grant,
    output logic               grant_valid
);

    logic [GW-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = GW'((int'(last_grant) + k) % NUM_REQ);
            if (!grant_valid && pending[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C command engine between NUM_REQ requesters: latches each
// request, grants round-robin, and returns completion/timeout per requester.
//
//   state    | meaning
//   ST_IDLE  | no command in flight; grant the next pending requester
//   ST_ISSUE | start strobe to the engine for the granted command
//   ST_WAIT  | waiting for engine completion or timer expiry
//   ST_DONE  | completion/timeout strobe back to the granted requester
module i2c_cmd_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int          NUM_REQ = 3,
    parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_pulse,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [8*NUM_REQ-1:0]   req_id,
    input  logic [8*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     req_busy,
    output logic [NUM_REQ-1:0]     rsp_cmplt,
    output logic [NUM_REQ-1:0]     rsp_timeout,
    output logic [7:0]             rsp_rdata,
    output logic                   IO_CONTROL_PULSE,
    output logic                   IO_CONTROL_RW,
    output logic [7:0]             IO_CONTROL_ID,
    output logic [7:0]             IO_ADDR_ADDR,
    output logic [7:0]             IO_WDATA_WDATA,
    input  logic [7:0]             IO_RDATA_RDATA,
    input  logic                   IO_CONTROL_CMPLT,
    output logic [7:0]             dbg_cstate
);

    localparam int            GW       = grant_w(NUM_REQ);
    localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);

    state_t                  state_q, state_d;
    logic [NUM_REQ-1:0]      pending_q, pending_d;
    logic [NUM_REQ-1:0]      rw_q, rw_d;
    logic [NUM_REQ-1:0][7:0] id_q, id_d;
    logic [NUM_REQ-1:0][7:0] addr_q, addr_d;
    logic [NUM_REQ-1:0][7:0] wdata_q, wdata_d;
    logic [GW-1:0]           last_grant_q, last_grant_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [15:0]             timer_q, timer_d;
    logic                    timed_out_q, timed_out_d;
    logic [7:0]              rdata_q, rdata_d;
    logic                    io_rw_q, io_rw_d;
    logic [7:0]              io_id_q, io_id_d;
    logic [7:0]              io_addr_q, io_addr_d;
    logic [7:0]              io_wdata_q, io_wdata_d;

    logic [GW-1:0]           pick;
    logic                    pick_valid;

    i2c_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_rr_pick (
        .pending     (pending_q),
        .last_grant  (last_grant_q),
        .grant       (pick),
        .grant_valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            rw_q         <= '0;
            id_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_grant_q <= LAST_RST;
            grant_q      <= '0;
            timer_q      <= '0;
            timed_out_q  <= 1'b0;
            rdata_q      <= '0;
            io_rw_q      <= 1'b0;
            io_id_q      <= '0;
            io_addr_q    <= '0;
            io_wdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            rw_q         <= rw_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            timer_q      <= timer_d;
            timed_out_q  <= timed_out_d;
            rdata_q      <= rdata_d;
            io_rw_q      <= io_rw_d;
            io_id_q      <= io_id_d;
            io_addr_q    <= io_addr_d;
            io_wdata_q   <= io_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (IO_CONTROL_CMPLT || timer_q == 16'd0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        rw_d      = rw_q;
        id_d      = id_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        // A requester being completed this cycle may re-request; set wins.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_pulse[i] && (!pending_q[i] || rsp_cmplt[i])) begin
                pending_d[i] = 1'b1;
                rw_d[i]      = req_rw[i];
                id_d[i]      = req_id[8*i +: 8];
                addr_d[i]    = req_addr[8*i +: 8];
                wdata_d[i]   = req_wdata[8*i +: 8];
            end else if (rsp_cmplt[i]) begin
                pending_d[i] = 1'b0;
            end
        end

        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        timed_out_d  = timed_out_q;
        rdata_d      = rdata_q;
        io_rw_d      = io_rw_q;
        io_id_d      = io_id_q;
        io_addr_d    = io_addr_q;
        io_wdata_d   = io_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    io_rw_d      = rw_q[pick];
                    io_id_d      = id_q[pick];
                    io_addr_d    = addr_q[pick];
                    io_wdata_d   = wdata_q[pick];
                    timed_out_d  = 1'b0;
                    rdata_d      = 8'h00;
                end
            end
            ST_ISSUE: timer_d = TIMEOUT;
            ST_WAIT: begin
                // Completion wins over an expiring timer in the same cycle.
                if (IO_CONTROL_CMPLT) begin
                    timed_out_d = 1'b0;
                    rdata_d     = (io_rw_q == READ_OP) ? IO_RDATA_RDATA : 8'h00;
                end else if (timer_q == 16'd0) begin
                    timed_out_d = 1'b1;
                    rdata_d     = 8'h00;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rsp_cmplt   = '0;
        rsp_timeout = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (state_q == ST_DONE && grant_q == GW'(i)) begin
                rsp_cmplt[i]   = 1'b1;
                rsp_timeout[i] = timed_out_q;
            end
        end
        rsp_rdata        = (state_q == ST_DONE) ? rdata_q : 8'h00;
        req_busy         = pending_q;
        IO_CONTROL_PULSE = (state_q == ST_ISSUE);
        IO_CONTROL_RW    = io_rw_q;
        IO_CONTROL_ID    = io_id_q;
        IO_ADDR_ADDR     = io_addr_q;
        IO_WDATA_WDATA   = io_wdata_q;
        dbg_cstate       = {6'b000000, state_q};
    end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Self-checking bench for i2c_cmd_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_i2c_cmd_arbiter;

    localparam int          N  = 3;
    localparam logic [15:0] TO = 16'd16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_pulse, req_rw;
    logic [8*N-1:0] req_id, req_addr, req_wdata;
    logic [N-1:0]   req_busy, rsp_cmplt, rsp_timeout;
    logic [7:0]     rsp_rdata;
    logic           IO_CONTROL_PULSE, IO_CONTROL_RW;
    logic [7:0]     IO_CONTROL_ID, IO_ADDR_ADDR, IO_WDATA_WDATA;
    logic [7:0]     IO_RDATA_RDATA;
    logic           IO_CONTROL_CMPLT;
    logic [7:0]     dbg_cstate;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] seen_ids[$];

    always #5 clk = ~clk;

    i2c_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_pulse(req_pulse), .req_rw(req_rw), .req_id(req_id),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_busy(req_busy), .rsp_cmplt(rsp_cmplt), .rsp_timeout(rsp_timeout),
        .rsp_rdata(rsp_rdata),
        .IO_CONTROL_PULSE(IO_CONTROL_PULSE), .IO_CONTROL_RW(IO_CONTROL_RW),
        .IO_CONTROL_ID(IO_CONTROL_ID), .IO_ADDR_ADDR(IO_ADDR_ADDR),
        .IO_WDATA_WDATA(IO_WDATA_WDATA), .IO_RDATA_RDATA(IO_RDATA_RDATA),
        .IO_CONTROL_CMPLT(IO_CONTROL_CMPLT), .dbg_cstate(dbg_cstate)
    );

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_pulse = '0; req_rw = '0; req_id = '0; req_addr = '0; req_wdata = '0;
        IO_RDATA_RDATA = 8'h00; IO_CONTROL_CMPLT = 1'b0;
    endtask

    // Leaves the bench at the negedge of the first post-reset cycle (cycle 0).
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic rw, input logic [7:0] id,
                           input logic [7:0] addr, input logic [7:0] wd);
        req_pulse[i] = 1'b1;
        req_rw[i] = rw;
        req_id[8*i +: 8] = id;
        req_addr[8*i +: 8] = addr;
        req_wdata[8*i +: 8] = wd;
    endtask

    // Runs ncyc cycles as an engine answering one cycle after each start strobe.
    task automatic collect(input int ncyc);
        logic cm_next = 1'b0;
        seen_ids.delete();
        for (int c = 0; c < ncyc; c++) begin
            IO_CONTROL_CMPLT = cm_next;
            cm_next = IO_CONTROL_PULSE;
            if (IO_CONTROL_PULSE) seen_ids.push_back(IO_CONTROL_ID);
            step();
        end
        IO_CONTROL_CMPLT = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        set_req(1, 1'b1, 8'hAA, 8'hBB, 8'hCC);
        step(); req_pulse = '0; step(2);
        do_reset();
        n_tests++; if (req_busy !== '0) begin n_fail++; $display("FAIL reset_busy: got %b exp 000", req_busy); end
        n_tests++; if (dbg_cstate !== 8'h00) begin n_fail++; $display("FAIL reset_state: got %h exp 00", dbg_cstate); end
        n_tests++; if ({rsp_cmplt, rsp_timeout, rsp_rdata} !== '0) begin n_fail++; $display("FAIL reset_rsp: got %b/%b/%h exp 0", rsp_cmplt, rsp_timeout, rsp_rdata); end
        n_tests++; if ({IO_CONTROL_PULSE, IO_CONTROL_RW, IO_CONTROL_ID, IO_ADDR_ADDR, IO_WDATA_WDATA} !== '0) begin
            n_fail++; $display("FAIL reset_io: got %b %b %h %h %h exp 0", IO_CONTROL_PULSE, IO_CONTROL_RW, IO_CONTROL_ID, IO_ADDR_ADDR, IO_WDATA_WDATA); end
    endtask

    task automatic test_write();
        do_reset();
        set_req(1, 1'b0, 8'h40, 8'h03, 8'h06);
        step(); req_pulse = '0;
        n_tests++; if (IO_CONTROL_PULSE !== 1'b0) begin n_fail++; $display("FAIL wr_pulse_c1: got %b exp 0", IO_CONTROL_PULSE); end
        step();
        n_tests++; if (IO_CONTROL_PULSE !== 1'b1) begin n_fail++; $display("FAIL wr_pulse_c2: got %b exp 1", IO_CONTROL_PULSE); end
        n_tests++; if ({IO_CONTROL_RW, IO_CONTROL_ID, IO_ADDR_ADDR, IO_WDATA_WDATA} !== {1'b0, 8'h40, 8'h03, 8'h06}) begin
            n_fail++; $display("FAIL wr_fields: got %b %h %h %h exp 0 40 03 06", IO_CONTROL_RW, IO_CONTROL_ID, IO_ADDR_ADDR, IO_WDATA_WDATA); end
        step(8);
        IO_CONTROL_CMPLT = 1'b1; IO_RDATA_RDATA = 8'h5A;
        step();
        IO_CONTROL_CMPLT = 1'b0;
        n_tests++; if ({rsp_cmplt, rsp_timeout, rsp_rdata} !== {3'b010, 3'b000, 8'h00}) begin
            n_fail++; $display("FAIL wr_rsp_c11: got %b %b %h exp 010 000 00", rsp_cmplt, rsp_timeout, rsp_rdata); end
        step();
        n_tests++; if (req_busy !== 3'b000 || IO_CONTROL_ID !== 8'h40) begin
            n_fail++; $display("FAIL wr_after: busy %b id %h exp 000 40", req_busy, IO_CONTROL_ID); end
    endtask

    task automatic test_read();
        do_reset();
        set_req(0, 1'b1, 8'h40, 8'h00, 8'h00);
        step(); req_pulse = '0;
        step(3);
        IO_CONTROL_CMPLT = 1'b1; IO_RDATA_RDATA = 8'h04;
        step();
        IO_CONTROL_CMPLT = 1'b0; IO_RDATA_RDATA = 8'hFF;
        n_tests++; if (rsp_cmplt !== 3'b001 || rsp_rdata !== 8'h04) begin
            n_fail++; $display("FAIL rd_rsp: got %b %h exp 001 04", rsp_cmplt, rsp_rdata); end
        n_tests++; if (req_busy[0] !== 1'b1) begin n_fail++; $display("FAIL rd_busy_done: got %b exp 1", req_busy[0]); end
        step();
        n_tests++; if (req_busy[0] !== 1'b0) begin n_fail++; $display("FAIL rd_busy_after: got %b exp 0", req_busy[0]); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h10 + i), 8'h00, 8'h00);
            step(); req_pulse = '0;
            collect(40);
            n_tests++; if (seen_ids.size() != N) begin n_fail++; $display("FAIL rr_count r%0d: got %0d exp %0d", round, seen_ids.size(), N); end
            for (int k = 0; k < N && k < seen_ids.size(); k++) begin
                n_tests++; if (seen_ids[k] !== 8'(8'h10 + k)) begin
                    n_fail++; $display("FAIL rr_order r%0d k%0d: got %h exp %h", round, k, seen_ids[k], 8'(8'h10 + k)); end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        set_req(2, 1'b0, 8'h50, 8'h01, 8'h02);
        step(); req_pulse = '0;
        step(18);
        n_tests++; if (rsp_cmplt !== 3'b000) begin n_fail++; $display("FAIL to_early: got %b exp 000", rsp_cmplt); end
        step();
        n_tests++; if ({rsp_cmplt, rsp_timeout, rsp_rdata} !== {3'b100, 3'b100, 8'h00}) begin
            n_fail++; $display("FAIL to_rsp: got %b %b %h exp 100 100 00", rsp_cmplt, rsp_timeout, rsp_rdata); end
        step();
        set_req(2, 1'b1, 8'h51, 8'h01, 8'h02);
        step(); req_pulse = '0;
        step(18);
        IO_CONTROL_CMPLT = 1'b1; IO_RDATA_RDATA = 8'h77;
        step();
        IO_CONTROL_CMPLT = 1'b0;
        n_tests++; if ({rsp_cmplt, rsp_timeout, rsp_rdata} !== {3'b100, 3'b000, 8'h77}) begin
            n_fail++; $display("FAIL to_edge: got %b %b %h exp 100 000 77", rsp_cmplt, rsp_timeout, rsp_rdata); end
    endtask

    task automatic test_dup_and_reset();
        logic bad;
        do_reset();
        set_req(2, 1'b0, 8'h21, 8'h00, 8'h00);
        step(); req_pulse = '0;
        set_req(2, 1'b1, 8'h99, 8'h00, 8'h00);
        step(); req_pulse = '0;
        collect(20);
        n_tests++; if (seen_ids.size() != 1) begin n_fail++; $display("FAIL dup_count: got %0d exp 1", seen_ids.size()); end
        else begin n_tests++; if (seen_ids[0] !== 8'h21) begin n_fail++; $display("FAIL dup_id: got %h exp 21", seen_ids[0]); end end
        do_reset();
        set_req(1, 1'b0, 8'h33, 8'h00, 8'h00);
        step(); req_pulse = '0;
        step(2);
        n_tests++; if (dbg_cstate !== 8'h02) begin n_fail++; $display("FAIL rstw_state: got %h exp 02", dbg_cstate); end
        rst = 1'b1; step(); rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            IO_CONTROL_CMPLT = (c == 1);
            if (rsp_cmplt !== '0 || dbg_cstate !== 8'h00 || req_busy !== '0) bad = 1'b1;
            step();
        end
        IO_CONTROL_CMPLT = 1'b0;
        n_tests++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rstw_late_cmplt: got activity %b exp 0", bad); end
    endtask

    // Model tracks pending requests and in-flight command at transaction level.
    task automatic test_random();
        logic [N-1:0] m_pend, m_pend_prev, exp_cm;
        logic         m_rw[N];
        logic [7:0]   m_id[N], m_addr[N], m_wd[N];
        logic [7:0]   exp_rdata;
        logic         exp_pulse, in_wait, exp_to, inflight, found, clr;
        int           last, g, idle_from, pulse_cyc, cmplt_cyc, rsp_cyc;
        do_reset();
        m_pend = '0; m_pend_prev = '0; last = N - 1; g = 0; idle_from = 0;
        inflight = 1'b0; exp_to = 1'b0; exp_rdata = 8'h00;
        pulse_cyc = -100; cmplt_cyc = -100; rsp_cyc = -100;
        for (int i = 0; i < N; i++) begin m_rw[i] = 1'b0; m_id[i] = 8'h00; m_addr[i] = 8'h00; m_wd[i] = 8'h00; end
        for (int t = 0; t < 2500; t++) begin
            exp_pulse = 1'b0;
            if (!inflight && t - 1 >= idle_from && m_pend_prev != '0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++)
                    if (!found && m_pend_prev[(last + k) % N]) begin g = (last + k) % N; found = 1'b1; end
                last = g; inflight = 1'b1; exp_pulse = 1'b1; pulse_cyc = t; exp_rdata = 8'h00;
                if ($urandom_range(3) == 0) begin exp_to = 1'b1; cmplt_cyc = -100; rsp_cyc = t + 18; end
                else begin exp_to = 1'b0; cmplt_cyc = t + 1 + int'($urandom_range(16)); rsp_cyc = cmplt_cyc + 1; end
            end
            n_tests++; if (IO_CONTROL_PULSE !== exp_pulse) begin n_fail++; $display("FAIL rnd_pulse t%0d: got %b exp %b", t, IO_CONTROL_PULSE, exp_pulse); end
            if (exp_pulse) begin
                n_tests++; if ({IO_CONTROL_RW, IO_CONTROL_ID, IO_ADDR_ADDR, IO_WDATA_WDATA} !== {m_rw[g], m_id[g], m_addr[g], m_wd[g]}) begin
                    n_fail++; $display("FAIL rnd_fields t%0d: got %b %h %h %h exp %b %h %h %h", t, IO_CONTROL_RW, IO_CONTROL_ID,
                                       IO_ADDR_ADDR, IO_WDATA_WDATA, m_rw[g], m_id[g], m_addr[g], m_wd[g]); end
            end
            exp_cm = (inflight && t == rsp_cyc) ? (N'(1) << g) : '0;
            n_tests++; if (rsp_cmplt !== exp_cm || rsp_timeout !== (exp_to ? exp_cm : '0)) begin
                n_fail++; $display("FAIL rnd_rsp t%0d: got %b %b exp %b to=%b", t, rsp_cmplt, rsp_timeout, exp_cm, exp_to); end
            if (exp_cm != '0) begin
                n_tests++; if (rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata t%0d: got %h exp %h", t, rsp_rdata, exp_rdata); end
            end
            n_tests++; if (req_busy !== m_pend) begin n_fail++; $display("FAIL rnd_busy t%0d: got %b exp %b", t, req_busy, m_pend); end

            IO_RDATA_RDATA = 8'($urandom_range(255));
            in_wait = inflight && t > pulse_cyc && t < rsp_cyc;
            IO_CONTROL_CMPLT = in_wait ? (t == cmplt_cyc) : ($urandom_range(7) == 0);
            if (in_wait && t == cmplt_cyc) exp_rdata = m_rw[g] ? IO_RDATA_RDATA : 8'h00;
            for (int i = 0; i < N; i++) begin
                req_pulse[i] = ($urandom_range(5) == 0);
                req_rw[i] = 1'($urandom_range(1));
                req_id[8*i +: 8] = 8'($urandom_range(255));
                req_addr[8*i +: 8] = 8'($urandom_range(255));
                req_wdata[8*i +: 8] = 8'($urandom_range(255));
            end

            m_pend_prev = m_pend;
            for (int i = 0; i < N; i++) begin
                clr = inflight && t == rsp_cyc && g == i;
                if (req_pulse[i] && (!m_pend[i] || clr)) begin
                    m_pend[i] = 1'b1; m_rw[i] = req_rw[i]; m_id[i] = req_id[8*i +: 8];
                    m_addr[i] = req_addr[8*i +: 8]; m_wd[i] = req_wdata[8*i +: 8];
                end else if (clr) begin
                    m_pend[i] = 1'b0;
                end
            end
            if (inflight && t == rsp_cyc) begin inflight = 1'b0; idle_from = t + 1; end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_timeout();
        test_dup_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_arbiter.md
I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, giving the number of requesters sharing one I2C command engine.
REQ-002 The block SHALL have parameter TIMEOUT, 16 bits, default 16'hFFFF, giving the wait-for-complete limit in clk cycles.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_pulse  in  NUM_REQ  one-cycle command request per requester.
- req_rw  in  NUM_REQ  1 = read, 0 = write.
- req_id  in  8*NUM_REQ  device ID; requester i uses bits [8i+7:8i].
- req_addr  in  8*NUM_REQ  register address, same packing as req_id.
- req_wdata  in  8*NUM_REQ  write data, same packing as req_id.
- req_busy  out  NUM_REQ  request pending or in flight.
- rsp_cmplt  out  NUM_REQ  one-cycle completion strobe.
- rsp_timeout  out  NUM_REQ  one-cycle strobe, coincident with rsp_cmplt, when the engine timed out.
- rsp_rdata  out  8  read data, valid while rsp_cmplt is high.
- IO_CONTROL_PULSE  out  1  engine start strobe.
- IO_CONTROL_RW  out  1  engine operation.
- IO_CONTROL_ID  out  8  engine device ID.
- IO_ADDR_ADDR  out  8  engine register address.
- IO_WDATA_WDATA  out  8  engine write data.
- IO_RDATA_RDATA  in  8  engine read data.
- IO_CONTROL_CMPLT  in  1  engine completion strobe.
- dbg_cstate  out  8  current FSM state.

Function
REQ-004 On req_pulse[i] with pending[i]=0, the block SHALL latch requester i's rw/id/addr/wdata and set pending[i] on the next cycle.
REQ-005 A req_pulse[i] arriving while pending[i]=1 SHALL be ignored, with latched fields unchanged.
REQ-006 req_busy SHALL equal pending, and pending[i] SHALL clear in the cycle rsp_cmplt[i] is high.
REQ-007 The FSM SHALL have states ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2, ST_DONE=3.
REQ-008 IDLE SHALL go to ISSUE when any pending bit is set, registering grant g at that transition.
REQ-009 ISSUE SHALL always go to WAIT after one cycle.
REQ-010 WAIT SHALL go to DONE on IO_CONTROL_CMPLT or when the timer reaches zero.
REQ-011 DONE SHALL always go to IDLE after one cycle.
REQ-012 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 wins first.
REQ-013 IO_CONTROL_PULSE SHALL be high exactly in cycles where cstate==ST_ISSUE.
REQ-014 IO_CONTROL_RW/ID/ADDR/WDATA SHALL carry requester g's latched fields from ISSUE through DONE, and hold their last value otherwise.
REQ-015 Latency: with the block idle and req_pulse[i] in cycle 0, IO_CONTROL_PULSE SHALL be high in cycle 2.
REQ-016 IO_CONTROL_CMPLT seen in WAIT in cycle k SHALL produce rsp_cmplt[g]=1 in cycle k+1, and the earliest next IO_CONTROL_PULSE in cycle k+3.
REQ-017 rsp_rdata SHALL capture IO_RDATA_RDATA on completion when rw=1, and SHALL be 0 for writes and timeouts.
REQ-018 The timer SHALL load TIMEOUT on entry to WAIT and decrement each WAIT cycle.
REQ-019 When the timer reaches 0 in WAIT without IO_CONTROL_CMPLT, the block SHALL pulse rsp_cmplt[g] and rsp_timeout[g] in the DONE cycle.
REQ-020 IO_CONTROL_CMPLT and timer==0 in the same cycle SHALL count as normal completion, with no timeout.
REQ-021 IO_CONTROL_CMPLT outside WAIT SHALL be ignored.
REQ-022 req_pulse[g] in the DONE cycle SHALL be accepted as a new request; a set wins over a clear for pending.
REQ-023 Any requester's pulse arriving in any state SHALL be latched per REQ-004 without disturbing the in-flight command.

Reset
REQ-024 On rst, the block SHALL set cstate=ST_IDLE, pending=0, last_grant=NUM_REQ-1, timer=0, and all outputs to 0 on the next clk edge.
REQ-025 Reset asserted mid-transaction SHALL abandon it with no rsp_cmplt, and the block SHALL ignore a later IO_CONTROL_CMPLT from that transaction.

Structure
REQ-026 Package i2c_arb_pkg SHALL hold the state encodings, READ_OP=1'b1, WRITE_OP=1'b0, and the TIMEOUT default.
REQ-027 The round-robin pick SHALL be one combinational sub-module i2c_arb_rr_pick(pending, last_grant -> grant, grant_valid).

Verification
REQ-028 Requester 1 write (ID 8'h40, addr 8'h03, wdata 8'h06) at cycle 0 -> IO_CONTROL_PULSE in cycle 2 with those fields; CMPLT at cycle 10 -> rsp_cmplt[1] in cycle 11 with rsp_rdata=0.
REQ-029 Requester 0 read (ID 8'h40, addr 8'h00); engine returns 8'h04 -> rsp_rdata=8'h04 with rsp_cmplt[0], and req_busy[0] clear the following cycle.
REQ-030 All three requesters pulse in the same cycle after reset -> grants in order 0, 1, 2; a second round of pulses -> order 0, 1, 2 again.
REQ-031 TIMEOUT=16 and no CMPLT -> rsp_cmplt[g] and rsp_timeout[g] 17 cycles after WAIT entry; CMPLT and timer zero in the same cycle -> no rsp_timeout.
REQ-032 Duplicate req_pulse[2] while busy -> ignored (single engine command); rst in WAIT followed by a late CMPLT -> no rsp_cmplt and FSM stays in IDLE.
